instr_queue: RTL
================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pipe_in  input  pipe_in_t (67)  fetched entry: pc[31:0], instruction[31:0], prediction, branch, jump.
REQ-006 enq_valid  input  1  pipe_in holds a valid fetched instruction this cycle.
REQ-007 enable  output  1  fetch may advance; drives the fetch stage's enable.
REQ-008 deq_ready  input  1  downstream decode/issue accepts the head entry this cycle.
REQ-009 deq_valid  output  1  head entry valid on pipe_out.
REQ-010 pipe_out  output  pipe_in_t (67)  head entry, all fields unmodified from enqueue.
REQ-011 flush  input  1  mispredict/redirect; discard all entries.
REQ-012 count  output  CW  current number of valid entries.
REQ-013 full, empty  output  1 each  occupancy flags.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH pipe_in_t entries, with head pointer, tail pointer and count registers.
REQ-015 Enqueue fire SHALL be enq_valid & !full & !flush; pipe_in is written at tail and tail advances by 1.
REQ-016 Dequeue fire SHALL be deq_valid & deq_ready & !flush; head advances by 1.
REQ-017 enable SHALL equal !full, combinationally, with no dependence on deq_ready (no same-cycle pass-through when full).
REQ-018 deq_valid SHALL equal !empty; pipe_out SHALL be the entry at head, combinationally from storage.
REQ-019 Latency: an entry enqueued in cycle N SHALL first appear on pipe_out in cycle N+1 (no fall-through bypass when empty).
REQ-020 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0) without skipping or duplicating entries.
REQ-021 count SHALL update as +1 on enqueue only, -1 on dequeue only, and unchanged when both or neither fire.
REQ-022 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0).
REQ-023 Simultaneous enqueue and dequeue when not full and not empty SHALL both take effect in the same cycle.
REQ-024 Enqueue while full SHALL be ignored with no state change; fetch is responsible for holding its entry while enable=0.
REQ-025 Dequeue while empty SHALL be ignored (deq_ready with deq_valid=0 has no effect).
REQ-026 flush SHALL take priority over enqueue and dequeue: next cycle head=tail=0, count=0, and any same-cycle enq/deq is discarded.
REQ-027 Entry contents SHALL NOT be cleared on flush or reset; only the pointers and count are reset.
REQ-028 Order SHALL be strict FIFO; no reordering or dropping except by flush.

Reset
REQ-029 While reset=1 at a rising edge: head=0, tail=0, count=0; the next cycle SHALL show empty=1, full=0, deq_valid=0, enable=1.
REQ-030 reset SHALL take priority over flush, enqueue and dequeue.
REQ-031 reset asserted mid-operation SHALL discard all entries exactly as flush does.

Verification
REQ-032 Fill: after reset, enqueue 8 entries with pc 0x0,0x4,...,0x1C and deq_ready=0 -> count=8, full=1, enable=0; a 9th enq_valid leaves state unchanged.
REQ-033 Drain order: from full, hold deq_ready=1 for 8 cycles -> pipe_out.pc = 0x0..0x1C in order with all fields intact, then empty=1.
REQ-034 Wrap/concurrent: keep count=4, enqueue and dequeue every cycle for 20 cycles -> count stays 4, output pc sequence is contiguous, pointers wrap cleanly.
REQ-035 Flush priority: count=5 with enq_valid=1 and deq_ready=1 plus flush=1 -> next cycle count=0, deq_valid=0, enable=1, and no entry consumed.
REQ-036 Latency: enqueue into an empty queue in cycle N -> deq_valid=0 in N, deq_valid=1 in N+1 with matching pc/instruction/prediction/branch/jump.
REQ-037 Reset mid-operation: count=3 plus reset=1 for 1 cycle -> count=0, empty=1; the next enqueue appears as the sole head entry.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: circular instruction buffer between fetch and decode/issue.
// Revision: 1.0
`default_nettype none

package instr_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        prediction;
    logic        branch;
    logic        jump;
  } pipe_in_t;
endpackage

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  pipe_in_t      pipe_in,
  input  logic          enq_valid,
  output logic          enable,
  input  logic          deq_ready,
  output logic          deq_valid,
  output pipe_in_t      pipe_out,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  pipe_in_t        mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            enq_fire;
  logic            deq_fire;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign enable    = !full;
  assign deq_valid = !empty;
  assign pipe_out  = mem[head];

  assign enq_fire = enq_valid & !full & !flush;
  assign deq_fire = deq_valid & deq_ready & !flush;

  // Storage has no reset: only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!reset && enq_fire) begin
      mem[tail] <= pipe_in;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire
